// File: rtl/window_filter_overlay.sv
// 3x3 window consumer: majority vote on the chroma-key decision bits, VGA stream
// rebuild with mask overlay, and per-frame detection statistics.
module window_filter_overlay #(
   parameter int          BUS_SIZE    = 28,
   parameter int          MIN_COUNT   = 5,
   parameter logic [23:0] OVERLAY_RGB = 24'hFF0000,
   parameter int          CNT_W       = 20,
   parameter int          COORD_W     = 13
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                EN,
   input  logic [1:0]          mode,
   input  logic [BUS_SIZE-1:0] tap_x0y0,
   input  logic [BUS_SIZE-1:0] tap_x1y0,
   input  logic [BUS_SIZE-1:0] tap_x2y0,
   input  logic [BUS_SIZE-1:0] tap_x0y1,
   input  logic [BUS_SIZE-1:0] tap_x1y1,
   input  logic [BUS_SIZE-1:0] tap_x2y1,
   input  logic [BUS_SIZE-1:0] tap_x0y2,
   input  logic [BUS_SIZE-1:0] tap_x1y2,
   input  logic [BUS_SIZE-1:0] tap_x2y2,
   output logic [7:0]          R_out,
   output logic [7:0]          G_out,
   output logic [7:0]          B_out,
   output logic                BLANK_N_out,
   output logic                VS_out,
   output logic                HS_out,
   output logic                detect_out,
   output logic [CNT_W-1:0]    frame_count,
   output logic [COORD_W-1:0]  bbox_xmin,
   output logic [COORD_W-1:0]  bbox_xmax,
   output logic [COORD_W-1:0]  bbox_ymin,
   output logic [COORD_W-1:0]  bbox_ymax,
   output logic                bbox_valid,
   output logic                frame_valid
);

   localparam logic [3:0]         MIN_CNT   = 4'(MIN_COUNT);
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};

   // Only the decision bit is taken from the eight neighbour taps.
   logic unused_tap_bits;
   assign unused_tap_bits = ^{tap_x0y0[27:1], tap_x1y0[27:1], tap_x2y0[27:1],
                              tap_x0y1[27:1], tap_x2y1[27:1],
                              tap_x0y2[27:1], tap_x1y2[27:1], tap_x2y2[27:1]};

   logic [23:0] rgb_s1;
   logic        blank_s1, vs_s1, hs_s1, dec_s1;
   logic [1:0]  rsum0_s1, rsum1_s1, rsum2_s1;

   logic        blank_d, vs_d;
   logic [COORD_W-1:0] col, row;

   logic [CNT_W-1:0]   acc_count;
   logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

   logic [1:0]  rsum0, rsum1, rsum2;
   logic [3:0]  vote_sum;
   logic        detect;
   logic        frame_end, line_end;
   logic [23:0] rgb_mux;

   assign rsum0 = 2'(tap_x0y0[0]) + 2'(tap_x1y0[0]) + 2'(tap_x2y0[0]);
   assign rsum1 = 2'(tap_x0y1[0]) + 2'(tap_x1y1[0]) + 2'(tap_x2y1[0]);
   assign rsum2 = 2'(tap_x0y2[0]) + 2'(tap_x1y2[0]) + 2'(tap_x2y2[0]);

   assign vote_sum  = 4'(rsum0_s1) + 4'(rsum1_s1) + 4'(rsum2_s1);
   assign detect    = blank_s1 & (vote_sum >= MIN_CNT);
   assign frame_end = vs_d & ~vs_s1;
   assign line_end  = blank_d & ~blank_s1;

   always_comb begin
      rgb_mux = 24'h000000;
      if (blank_s1) begin
         case (mode)
            2'd0:    rgb_mux = rgb_s1;
            2'd1:    rgb_mux = detect ? OVERLAY_RGB : rgb_s1;
            2'd2:    rgb_mux = detect ? 24'hFFFFFF : 24'h000000;
            default: rgb_mux = dec_s1 ? 24'hFFFFFF : 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rgb_s1      <= '0;
         blank_s1    <= 1'b0;
         vs_s1       <= 1'b0;
         hs_s1       <= 1'b0;
         dec_s1      <= 1'b0;
         rsum0_s1    <= '0;
         rsum1_s1    <= '0;
         rsum2_s1    <= '0;
         R_out       <= '0;
         G_out       <= '0;
         B_out       <= '0;
         BLANK_N_out <= 1'b0;
         VS_out      <= 1'b0;
         HS_out      <= 1'b0;
         detect_out  <= 1'b0;
         blank_d     <= 1'b0;
         vs_d        <= 1'b0;
         col         <= '0;
         row         <= '0;
      end else if (EN) begin
         rgb_s1      <= tap_x1y1[27:4];
         blank_s1    <= tap_x1y1[3];
         vs_s1       <= tap_x1y1[2];
         hs_s1       <= tap_x1y1[1];
         dec_s1      <= tap_x1y1[0];
         rsum0_s1    <= rsum0;
         rsum1_s1    <= rsum1;
         rsum2_s1    <= rsum2;
         R_out       <= rgb_mux[23:16];
         G_out       <= rgb_mux[15:8];
         B_out       <= rgb_mux[7:0];
         BLANK_N_out <= blank_s1;
         VS_out      <= vs_s1;
         HS_out      <= hs_s1;
         detect_out  <= detect;
         blank_d     <= blank_s1;
         vs_d        <= vs_s1;
         if (!blank_s1)
            col <= '0;
         else if (col != COORD_MAX)
            col <= col + COORD_W'(1);
         if (!vs_s1)
            row <= '0;
         else if (line_end && row != COORD_MAX)
            row <= row + COORD_W'(1);
      end
   end

   // Frame end takes priority over accumulation so the edge pixel is never counted.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_count   <= '0;
         acc_xmin    <= COORD_MAX;
         acc_xmax    <= '0;
         acc_ymin    <= COORD_MAX;
         acc_ymax    <= '0;
         frame_count <= '0;
         bbox_xmin   <= '0;
         bbox_xmax   <= '0;
         bbox_ymin   <= '0;
         bbox_ymax   <= '0;
         bbox_valid  <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (EN) begin
            if (frame_end) begin
               frame_valid <= 1'b1;
               frame_count <= acc_count;
               bbox_valid  <= (acc_count != '0);
               bbox_xmin   <= (acc_count != '0) ? acc_xmin : '0;
               bbox_xmax   <= (acc_count != '0) ? acc_xmax : '0;
               bbox_ymin   <= (acc_count != '0) ? acc_ymin : '0;
               bbox_ymax   <= (acc_count != '0) ? acc_ymax : '0;
               acc_count   <= '0;
               acc_xmin    <= COORD_MAX;
               acc_xmax    <= '0;
               acc_ymin    <= COORD_MAX;
               acc_ymax    <= '0;
            end else if (detect) begin
               if (acc_count != CNT_MAX)
                  acc_count <= acc_count + CNT_W'(1);
               if (col < acc_xmin) acc_xmin <= col;
               if (col > acc_xmax) acc_xmax <= col;
               if (row < acc_ymin) acc_ymin <= row;
               if (row > acc_ymax) acc_ymax <= row;
            end
         end
      end
   end

endmodule
